// File: rtl/codec_clk_gen.sv
// codec_clk_gen: MCLK/BCLK/LRCK generator with bit/frame strobes for the
// WM8731 serial port. All outputs are registered.
// Optional feature macro: CODEC_CLK_I2S_DLY_EN (I2S one-bit LRCK lead);
// undefined builds left-justified framing.
module codec_clk_gen #(
  parameter int unsigned MCLK_DIV  = 4,
  parameter int unsigned BCLK_DIV  = 16,
  parameter int unsigned WORD_BITS = 16,
  parameter int unsigned CHANNELS  = 2,
  localparam int unsigned SLOT_W   = (CHANNELS > 2) ? $clog2(CHANNELS) : 1,
  localparam int unsigned BIT_W    = $clog2(WORD_BITS)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Enable,
  output logic              Mclk,
  output logic              Bclk,
  output logic              Lrck,
  output logic              BclkRiseStb,
  output logic              BclkFallStb,
  output logic              FrameStb,
  output logic [SLOT_W-1:0] Slot,
  output logic [BIT_W-1:0]  BitIdx,
  output logic              Running
);

  localparam int unsigned MC_W = (MCLK_DIV > 2) ? $clog2(MCLK_DIV / 2) : 1;
  localparam int unsigned BC_W = $clog2(BCLK_DIV);

  localparam logic [MC_W-1:0]   MC_LAST   = MC_W'(MCLK_DIV / 2 - 1);
  localparam logic [BC_W-1:0]   BC_LAST   = BC_W'(BCLK_DIV - 1);
  localparam logic [BC_W-1:0]   BC_HALF   = BC_W'(BCLK_DIV / 2);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_BITS - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CHANNELS - 1);
  localparam logic [SLOT_W-1:0] SLOT_HALF = SLOT_W'(CHANNELS / 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [MC_W-1:0]   mc_cnt_q, mc_cnt_d;
  logic              mclk_q, mclk_d;
  logic [BC_W-1:0]   bc_q, bc_d;
  logic              bclk_q, bclk_d;
  logic              lrck_q, lrck_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              frame_q, frame_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              running_q, running_d;
  logic [SLOT_W-1:0] slot_nxt;

  // Free-running master clock divider
  always_comb begin
    mc_cnt_d = mc_cnt_q + MC_W'(1);
    mclk_d   = mclk_q;
    if (mc_cnt_q == MC_LAST) begin
      mc_cnt_d = '0;
      mclk_d   = ~mclk_q;
    end
  end

  // Serial clock FSM: bit counter, bit/slot indices, LRCK and strobes
  always_comb begin
    state_d   = state_q;
    bc_d      = bc_q;
    bclk_d    = bclk_q;
    lrck_d    = lrck_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    frame_d   = 1'b0;
    slot_d    = slot_q;
    bit_d     = bit_q;
    running_d = running_q;
    slot_nxt  = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);

    case (state_q)
      ST_IDLE: begin
        bc_d = '0;
        if (Enable) begin
          state_d   = ST_RUN;
          frame_d   = 1'b1;
          running_d = 1'b1;
          lrck_d    = 1'b0;
        end
      end
      ST_RUN, ST_STOP: begin
        // Enable only steers the frame boundary decision; counting never pauses
        if (state_q == ST_RUN && !Enable) state_d = ST_STOP;
        if (state_q == ST_STOP && Enable) state_d = ST_RUN;

        if (bc_q == BC_LAST) begin
          bc_d   = '0;
          bclk_d = 1'b0;
          fall_d = 1'b1;
          if (bit_q == '0) begin
            bit_d  = BIT_LAST;
            slot_d = slot_nxt;
          end else begin
            bit_d = bit_q - BIT_W'(1);
          end
`ifdef CODEC_CLK_I2S_DLY_EN
          // Lead the slot boundary by one bit
          if (bit_q == BIT_W'(1)) lrck_d = (slot_nxt >= SLOT_HALF);
`else
          lrck_d = (slot_d >= SLOT_HALF);
`endif
          if (bit_q == '0 && slot_q == SLOT_LAST) begin
            if (state_q == ST_STOP && !Enable) begin
              state_d   = ST_IDLE;
              bclk_d    = 1'b0;
              lrck_d    = 1'b0;
              slot_d    = '0;
              bit_d     = BIT_LAST;
              running_d = 1'b0;
            end else begin
              frame_d = 1'b1;
            end
          end
        end else begin
          bc_d = bc_q + BC_W'(1);
          if (bc_d == BC_HALF) begin
            bclk_d = 1'b1;
            rise_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      mc_cnt_q  <= '0;
      mclk_q    <= 1'b0;
      bc_q      <= '0;
      bclk_q    <= 1'b0;
      lrck_q    <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      frame_q   <= 1'b0;
      slot_q    <= '0;
      bit_q     <= BIT_LAST;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mc_cnt_q  <= mc_cnt_d;
      mclk_q    <= mclk_d;
      bc_q      <= bc_d;
      bclk_q    <= bclk_d;
      lrck_q    <= lrck_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      frame_q   <= frame_d;
      slot_q    <= slot_d;
      bit_q     <= bit_d;
      running_q <= running_d;
    end
  end

  assign Mclk        = mclk_q;
  assign Bclk        = bclk_q;
  assign Lrck        = lrck_q;
  assign BclkRiseStb = rise_q;
  assign BclkFallStb = fall_q;
  assign FrameStb    = frame_q;
  assign Slot        = slot_q;
  assign BitIdx      = bit_q;
  assign Running     = running_q;

endmodule

// File: doc/codec_clk_gen.md
# codec_clk_gen

Parametrised synthesizable audio clock generator for the WM8731 codec controller. It derives MCLK, BCLK and LRCK from the system clock `Clk` and generalises divide ratios, word length and slot count. It also issues single-cycle strobes that the serialiser and deserialiser use to shift data. It sits between the system clock domain and the codec serial-port logic; all outputs are registered.

## Interface
- `MCLK_DIV`, 4, `Clk` cycles per `Mclk` period; even, ≥2
- `BCLK_DIV`, 16, `Clk` cycles per `Bclk` period; even, ≥2
- `WORD_BITS`, 16, bits per slot; ≥2
- `CHANNELS`, 2, slots per frame; even, ≥2
- `Clk` in 1: system clock; all logic on its rising edge
- `Rst` in 1: synchronous, active-high reset
- `Enable` in 1: request to run the serial clocks
- `Mclk` out 1: codec master clock
- `Bclk` out 1: bit clock
- `Lrck` out 1: frame/channel clock
- `BclkRiseStb` out 1: high in the cycle `Bclk` becomes 1
- `BclkFallStb` out 1: high in the cycle `Bclk` becomes 0
- `FrameStb` out 1: high for one cycle at the first bit of each frame
- `Slot` out max(1,clog2(CHANNELS)): current slot index
- `BitIdx` out clog2(WORD_BITS): current bit index, MSB first
- `Running` out 1: serial clocks active

## Operation
- Reset values:
  - `Mclk`, `Bclk`, `Lrck`, all strobes, `Slot` and `Running` = 0.
  - `BitIdx` = WORD_BITS-1.
  - FSM = IDLE.
- `Mclk` free-runs whenever `Rst` is low, independent of `Enable`. It toggles every MCLK_DIV/2 cycles.
- FSM states are IDLE, RUN and STOP.
  - IDLE: `Enable`=1 → RUN.
  - RUN: `Enable`=0 → STOP.
  - STOP: `Enable`=1 → RUN, with no gap and no counter reset.
  - STOP: at the last `Bclk` fall of the frame → IDLE.
- Bit counter `bc` runs 0..BCLK_DIV-1 in RUN and STOP and wraps to 0.
  - `bc` is held at 0 in IDLE.
  - `Bclk` rises on the edge where `bc` becomes BCLK_DIV/2.
  - `Bclk` falls on the edge where `bc` wraps to 0.
- Each `Bclk` fall decrements `BitIdx`.
  - From 0, `BitIdx` reloads WORD_BITS-1 and `Slot` increments mod CHANNELS.
- Left-justified `Lrck` = 1 while `Slot` ≥ CHANNELS/2. It is updated on the same edge as `Slot`.
- `FrameStb` pulses on the entry edge into RUN from IDLE.
- `FrameStb` also pulses on every fall where `Slot` wraps to 0 in RUN. It is not asserted on a wrap that ends STOP.
- Entering IDLE from STOP forces `Bclk`=0, `Lrck`=0, `Slot`=0, `BitIdx`=WORD_BITS-1 and `Running`=0 on that edge.
- If `Rst` is asserted mid-frame, every output takes its reset value on the next edge. There is no frame completion.

## Timing
- `Running` rises 1 cycle after `Enable` is sampled high in IDLE.
- The first `Bclk` rise occurs BCLK_DIV/2 cycles after `Running` rises.
- Frame length = CHANNELS·WORD_BITS·BCLK_DIV cycles; the default is 512.
- Strobes and `Bclk`/`Lrck`/`Slot`/`BitIdx` change on the same edge. Consumers sample them in the strobe cycle.
- `Enable` is deasserted at any point: the remainder of the frame completes. `Running` falls on the edge that ends the frame.
- `Enable` is deasserted and reasserted within the same frame: the pulse is ignored and timing is continuous.

## Configuration
- `CODEC_CLK_I2S_DLY_EN` defined (I2S mode): `Lrck` takes the next slot's value on the `Bclk` fall where `BitIdx` becomes 0, one bit before the slot boundary.
  - On the IDLE exit edge, `Lrck` is still forced to 0.
- `CODEC_CLK_I2S_DLY_EN` undefined: left-justified mode; `Lrck` changes together with `Slot`.

## Test plan
- Defaults, `Rst` held 3 cycles then released, `Enable`=0 → `Mclk` period 4 cycles; `Bclk`=0; `Running`=0; `BitIdx`=15.
- `Enable`=1 → `Running`=1 one cycle later, with `FrameStb` in the same cycle. The first `BclkRiseStb` comes 8 cycles later. `Bclk` period is 16 cycles, and `FrameStb` repeats every 512 cycles.
- Left-justified: `Lrck` is 0 for 256 cycles, then 1 for 256 cycles. `Lrck` rises with `Slot`=1, `BitIdx`=15.
- With `CODEC_CLK_I2S_DLY_EN`: `Lrck` rises 16 cycles earlier, on the fall where `Slot`=0 and `BitIdx` becomes 0.
- `Enable` is dropped at cycle 100 of a frame → clocks continue to the frame end (cycle 512). Then `Running`=0 and `Bclk`=0, with no `FrameStb`. Repeat with `Enable` dropped at 100 and reasserted at 200 → no interruption.
- `Rst` is pulsed at cycle 300 of a frame → on the next edge all outputs take their reset values and `Mclk` restarts from 0.
